// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared types and constants for the SPI master controller:
//               operation codes, FSM state encoding, frame sizes and a
//               helper that assembles the 11-bit TX frame.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        RECV = 3'd4,
        GAP  = 3'd5
    } state_e;

    localparam int FRAME_BITS = 11;
    localparam int RX_BITS    = 8;

    // The slave expects the op MSB twice: once as a read/write flag and
    // again as the top bit of the 2-bit operation field.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] op,
                                                          input logic [7:0] data);
        return {op[1], op, data};
    endfunction

endpackage : spi_master_pkg
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_shifter
// Description : 11-bit parallel-load TX shift register driving a registered
//               MOSI, plus the RX shift register that assembles the MISO byte
//               MSB first. All enables come from the controlling FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter
    import spi_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  shift_i,
    input  logic                  clr_mosi_i,
    input  logic                  sample_i,
    input  logic                  miso_i,
    output logic                  mosi_o,
    output logic [RX_BITS-1:0]    rx_byte_o
);

    logic [FRAME_BITS-1:0] tx_q;
    // Only the first seven samples are stored; the eighth is taken straight
    // from MISO so the completed byte can be registered on the final edge.
    logic [RX_BITS-2:0]    rx_q;
    logic                  mosi_q;

    assign rx_byte_o = {rx_q, miso_i};
    assign mosi_o    = mosi_q;

    // TX load/shift, MOSI register and RX capture; MISO is only looked at
    // while sampling so an undriven line cannot leak into the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            mosi_q <= 1'b0;
        end else begin
            if (load_i) begin
                tx_q <= frame_i;
            end else if (shift_i) begin
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end

            if (clr_mosi_i) begin
                mosi_q <= 1'b0;
            end else if (shift_i) begin
                mosi_q <= tx_q[FRAME_BITS-1];
            end

            if (sample_i) begin
                rx_q <= rx_byte_o[RX_BITS-2:0];
            end
        end
    end

endmodule : spi_master_shifter
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : Single-clock SPI master. Accepts one command per frame on a
//               valid/ready interface, serialises {op[1], op, data} on MOSI
//               under SS_n, and for read-data frames returns the MISO byte
//               on a one-cycle response strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int MIN_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // Counter reload values; one 4-bit down-counter serves every timed state.
    localparam logic [3:0] SEND_LOAD = 4'(FRAME_BITS - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] RECV_LOAD = 4'(RX_BITS - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(MIN_GAP - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ss_n_q, ss_n_d;
    logic         busy_q, busy_d;
    logic         rd_q, rd_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [7:0]   rsp_data_q, rsp_data_d;

    logic         ready_w;
    logic         load_w;
    logic         shift_w;
    logic         clr_mosi_w;
    logic         sample_w;
    logic [7:0]   rx_byte_w;

    spi_master_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_w),
        .frame_i    (build_frame(cmd_op, cmd_data)),
        .shift_i    (shift_w),
        .clr_mosi_i (clr_mosi_w),
        .sample_i   (sample_w),
        .miso_i     (MISO),
        .mosi_o     (MOSI),
        .rx_byte_o  (rx_byte_w)
    );

    // cmd_ready is masked by rst so nothing can handshake during reset.
    assign cmd_ready = ready_w & ~rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ss_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ss_n_q      <= ss_n_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic and shifter enables for the frame sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ss_n_d      = ss_n_q;
        busy_d      = busy_q;
        rd_d        = rd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        ready_w     = 1'b0;
        load_w      = 1'b0;
        shift_w     = 1'b0;
        clr_mosi_w  = 1'b0;
        sample_w    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_w = 1'b1;
                if (cmd_valid) begin
                    load_w  = 1'b1;
                    rd_d    = (op_e'(cmd_op) == OP_RD_DATA);
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEL;
                end
            end
            SEL: begin
                shift_w = 1'b1;
                cnt_d   = SEND_LOAD;
                state_d = SEND;
            end
            SEND: begin
                if (cnt_q != 4'd0) begin
                    shift_w = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    // Last bit has been on the wire for a full cycle.
                    clr_mosi_w = 1'b1;
                    if (rd_q) begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end else begin
                        ss_n_d  = 1'b1;
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            WAIT: begin
                // Give the slave time to turn its rx byte into tx data.
                if (cnt_q == 4'd0) begin
                    cnt_d   = RECV_LOAD;
                    state_d = RECV;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECV: begin
                sample_w = 1'b1;
                if (cnt_q == 4'd0) begin
                    ss_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_byte_w;
                    cnt_d       = GAP_LOAD;
                    state_d     = GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : spi_master_ctrl
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Self-checking bench for spi_master_ctrl. Three instances with
//               different RD_WAIT/MIN_GAP share clock, reset and command
//               payload; each has its own valid line and MISO slave model.
//               Expected waveforms are computed from frame arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    function automatic int rdw_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    function automatic int mg_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 1 : 3;
    endfunction

    logic       clk;
    logic       rst;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] cmd_valid;
    logic [2:0] cmd_ready;
    logic [2:0] rsp_valid;
    logic [2:0] busy;
    logic [2:0] ss_n;
    logic [2:0] mosi;
    logic [2:0] miso;
    logic [7:0] rsp_data [3];

    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_rsp [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            spi_master_ctrl #(
                .RD_WAIT (rdw_of(g)),
                .MIN_GAP (mg_of(g))
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .cmd_valid (cmd_valid[g]),
                .cmd_ready (cmd_ready[g]),
                .cmd_op    (cmd_op),
                .cmd_data  (cmd_data),
                .rsp_valid (rsp_valid[g]),
                .rsp_data  (rsp_data[g]),
                .busy      (busy[g]),
                .SS_n      (ss_n[g]),
                .MOSI      (mosi[g]),
                .MISO      (miso[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // One complete frame on instance k, observed every cycle on the falling
    // edge. Cycle c is the state after the c-th rising edge past acceptance.
    task automatic do_frame(input int k, input logic [1:0] op, input logic [7:0] data,
                            input logic [7:0] sbyte, input bit hold, output int waited);
        int          rw;
        int          mg;
        int          len;
        logic [10:0] frame;
        logic [4:0]  exp_v;
        logic [4:0]  act_v;
        rw     = rdw_of(k);
        mg     = mg_of(k);
        frame  = {op[1], op, data};
        len    = (op == 2'b11) ? (12 + rw + 8) : 12;
        waited = 0;
        while (cmd_ready[k] !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (cmd_ready[k] !== 1'b1) begin
            fails++;
            $display("FAIL k%0d accept_timeout: cmd_ready=%b required 1", k, cmd_ready[k]);
            return;
        end
        cmd_op       = op;
        cmd_data     = data;
        cmd_valid[k] = 1'b1;
        for (int c = 0; c < len + mg; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) cmd_valid[k] = 1'b0;
            exp_v = {(c < len) ? 1'b0 : 1'b1,
                     (c >= 1 && c <= 11) ? frame[11-c] : 1'b0,
                     (op == 2'b11 && c == len) ? 1'b1 : 1'b0,
                     1'b1,
                     1'b0};
            act_v = {ss_n[k], mosi[k], rsp_valid[k], busy[k], cmd_ready[k]};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL k%0d op%0d cyc%0d {ss_n,mosi,rsp_valid,busy,ready}: got %b required %b",
                         k, op, c, act_v, exp_v);
            end
            if (op == 2'b11 && c == len) begin
                tests++;
                if (rsp_data[k] !== sbyte || $isunknown(rsp_data[k])) begin
                    fails++;
                    $display("FAIL k%0d rsp_data: got %h required %h", k, rsp_data[k], sbyte);
                end
            end
            // Slave model: present bit i just before the i-th sample edge,
            // leave the line unknown everywhere else.
            if (op == 2'b11 && c >= 12 + rw && c < 20 + rw)
                miso[k] = sbyte[7-(c-12-rw)];
            else
                miso[k] = 1'bx;
            if (hold) begin
                cmd_op   = 2'($urandom);
                cmd_data = 8'($urandom);
            end
        end
        if (op == 2'b11) last_rsp[k] = sbyte;
        @(negedge clk);
        tests++;
        if ({ss_n[k], busy[k], cmd_ready[k], rsp_valid[k], rsp_data[k]} !== {4'b1010, last_rsp[k]}) begin
            fails++;
            $display("FAIL k%0d post_gap {ss_n,busy,ready,rsp_valid,rsp_data}: got %b_%h required 1010_%h",
                     k, {ss_n[k], busy[k], cmd_ready[k], rsp_valid[k]}, rsp_data[k], last_rsp[k]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({ss_n[k], mosi[k], rsp_valid[k], busy[k], cmd_ready[k], rsp_data[k]} !== {5'b10000, 8'h00}) begin
                fails++;
                $display("FAIL k%0d reset_values {ss_n,mosi,rsp_valid,busy,ready}: got %b data %h required 10000 data 00",
                         k, {ss_n[k], mosi[k], rsp_valid[k], busy[k], cmd_ready[k]}, rsp_data[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 3'b111) begin
            fails++;
            $display("FAIL ready_after_reset: got %b required 111", cmd_ready);
        end
    endtask

    task automatic test_write_addr;
        int w;
        do_frame(0, 2'b00, 8'h5A, 8'h00, 1'b0, w);
    endtask

    task automatic test_write_data;
        int w;
        do_frame(0, 2'b01, 8'hC3, 8'h00, 1'b0, w);
    endtask

    task automatic test_read;
        int w;
        do_frame(0, 2'b10, 8'h5A, 8'h00, 1'b0, w);
        do_frame(0, 2'b11, 8'h00, 8'hA5, 1'b0, w);
    endtask

    task automatic test_back_to_back;
        int          w;
        logic [1:0]  ops [3];
        ops[0] = 2'b00;
        ops[1] = 2'b11;
        ops[2] = 2'b01;
        for (int j = 0; j < 3; j++) begin
            do_frame(0, ops[j], 8'($urandom), 8'($urandom), 1'b1, w);
            if (j > 0) begin
                tests++;
                if (w != 0) begin
                    fails++;
                    $display("FAIL back_to_back_wait j%0d: waited %0d cycles required 0", j, w);
                end
            end
        end
        cmd_valid[0] = 1'b0;
    endtask

    task automatic test_random;
        int w;
        for (int j = 0; j < 12; j++) begin
            do_frame(int'($urandom_range(0, 2)), 2'($urandom), 8'($urandom), 8'($urandom), 1'b0, w);
        end
    endtask

    task automatic test_rd_wait_sweep;
        int w;
        for (int k = 1; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                do_frame(k, 2'b10, 8'($urandom), 8'h00, 1'b0, w);
                do_frame(k, 2'b11, 8'($urandom), 8'($urandom), 1'b0, w);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        while (cmd_ready[0] !== 1'b1) @(negedge clk);
        cmd_op       = 2'b11;
        cmd_data     = 8'h3C;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ss_n[0], mosi[0], busy[0], cmd_ready[0], rsp_valid[0]} !== 5'b10000) begin
            fails++;
            $display("FAIL rst_mid_frame {ss_n,mosi,busy,ready,rsp_valid}: got %b required 10000",
                     {ss_n[0], mosi[0], busy[0], cmd_ready[0], rsp_valid[0]});
        end
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_rsp[k] = 8'h00;
        @(negedge clk);
        tests++;
        if (cmd_ready[0] !== 1'b1 || bad != 0) begin
            fails++;
            $display("FAIL rst_release: ready=%b required 1, bad cycles during rst %0d required 0",
                     cmd_ready[0], bad);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0 || ss_n[0] !== 1'b1 || rsp_data[0] !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abandoned_frame: %0d cycles with activity, required 0", bad);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 3'b000;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        miso      = 3'bxxx;
        for (int k = 0; k < 3; k++) last_rsp[k] = 8'h00;

        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_back_to_back();
        test_random();
        test_rd_wait_sweep();
        test_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_master_ctrl
`default_nettype wire
